serv_mem_arbiter: RTL and testbench
===================================

// Module: serv_mem_arbiter
// PURPOSE
//  Shares one Wishbone-classic memory port between the SERV ibus (read-only) and dbus.
//  Registered grant FSM with selectable tie-break and a bus-timeout watchdog that
//  terminates a hung transfer with an error strobe. Sits between serv_top and the
//  single-ported memory/interconnect.
// PARAMETERS
//  PRIO       "DBUS"  tie-break when both cyc high in IDLE: "DBUS" = dbus wins, "RR" = alternate
//  TIMEOUT_W  8       watchdog counter width; transfer aborted after 2**TIMEOUT_W-1 unacked cycles
//  WITH_TO    1       1 = watchdog enabled, 0 = wait forever (counter removed)
// PORTS
//  i_clk          in   1   clock
//  i_rst          in   1   asynchronous active-high reset
//  i_ibus_adr     in   32  instruction fetch address
//  i_ibus_cyc     in   1   fetch request, held until o_ibus_ack
//  o_ibus_rdt     out  32  fetched instruction, valid with o_ibus_ack
//  o_ibus_ack     out  1   one-cycle fetch completion strobe
//  i_dbus_adr     in   32  data address
//  i_dbus_dat     in   32  write data
//  i_dbus_sel     in   4   byte enables
//  i_dbus_we      in   1   1 = write
//  i_dbus_cyc     in   1   data request, held until o_dbus_ack
//  o_dbus_rdt     out  32  read data, valid with o_dbus_ack
//  o_dbus_ack     out  1   one-cycle data completion strobe
//  o_mem_adr      out  32  memory address (registered)
//  o_mem_dat      out  32  memory write data (registered)
//  o_mem_sel      out  4   memory byte enables (registered; 4'hF for ibus)
//  o_mem_we       out  1   memory write enable (registered; 0 for ibus)
//  o_mem_cyc      out  1   memory cycle/strobe (registered)
//  i_mem_rdt      in   32  memory read data
//  i_mem_ack      in   1   memory acknowledge
//  o_err          out  1   one-cycle strobe, coincident with ack, on watchdog termination
//  o_busy         out  1   high in any state except IDLE
// BEHAVIOUR
//  - States: IDLE, IBUS, DBUS, DONE. Reset (async): IDLE, all outputs 0, last-grant = ibus.
//  - IDLE: dbus_cyc&!ibus_cyc -> DBUS; ibus_cyc&!dbus_cyc -> IBUS; both -> PRIO rule
//    ("RR": grant the requester not granted last). On grant edge register adr/dat/sel/we,
//    set o_mem_cyc=1, clear watchdog, update last-grant.
//  - IBUS/DBUS: i_mem_ack sampled high -> DONE; capture i_mem_rdt into granted o_*_rdt,
//    pulse granted o_*_ack, o_mem_cyc=0. Other requester's rdt/ack untouched.
//  - Watchdog (WITH_TO=1): counts each IBUS/DBUS cycle without ack; at all-ones -> DONE with
//    o_*_ack=1, o_err=1, o_*_rdt=32'h0, o_mem_cyc=0. Ack on the terminal cycle wins (no err).
//  - Abort: granted requester's cyc low in IBUS/DBUS -> IDLE, o_mem_cyc=0, no ack, no err;
//    abort takes precedence over simultaneous i_mem_ack.
//  - DONE: exactly one cycle, acks/err deassert, -> IDLE. Requester drops cyc the cycle after
//    its ack, so it is never re-granted on a stale request.
//  - Latency: cyc rise cycle N -> o_mem_cyc cycle N+1; i_mem_ack cycle M -> o_*_ack cycle M+1.
//    Minimum request-to-ack = 2 cycles; back-to-back grants separated by DONE+IDLE.
//  - i_mem_ack outside IBUS/DBUS ignored. o_mem_adr/dat/sel/we hold last value while idle.
//  - Reset mid-transfer: immediate return to IDLE, o_mem_cyc and acks drop asynchronously.
// TESTING
//  - ibus_cyc=1 adr=0x100, mem acks first cycle rdt=0x00000013 -> o_mem_cyc N+1, o_ibus_ack N+2 rdt=0x13.
//  - Both cyc same cycle, PRIO="DBUS": dbus write 0xDEADBEEF sel=4'b0011 first, then ibus; PRIO="RR" twice -> grants alternate.
//  - No ack, TIMEOUT_W=4 -> ack+o_err after 15 cycles of o_mem_cyc, rdt=0, FSM back to IDLE.
//  - dbus_cyc dropped 2 cycles into grant with ack same cycle -> no o_dbus_ack, o_mem_cyc low next cycle.
//  - i_rst asserted mid-DBUS (async, between edges) -> o_mem_cyc=0, o_busy=0 before next edge; new ibus req served after release.
//  - Stray i_mem_ack in IDLE/DONE -> no ack, no err, no state change.

Source files
------------

// File: rtl/serv_mem_arbiter_if.sv
// serv_mem_arbiter_if: ibus, dbus and memory-side Wishbone signals of the arbiter
interface serv_mem_arbiter_if;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic [31:0] o_mem_adr;
    logic [31:0] o_mem_dat;
    logic [3:0]  o_mem_sel;
    logic        o_mem_we;
    logic        o_mem_cyc;
    logic [31:0] i_mem_rdt;
    logic        i_mem_ack;
    logic        o_err;
    logic        o_busy;
    modport slave (
        input  i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
               i_mem_rdt, i_mem_ack,
        output o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_mem_adr, o_mem_dat, o_mem_sel,
               o_mem_we, o_mem_cyc, o_err, o_busy
    );
    modport master (
        output i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
               i_mem_rdt, i_mem_ack,
        input  o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_mem_adr, o_mem_dat, o_mem_sel,
               o_mem_we, o_mem_cyc, o_err, o_busy
    );
endinterface

// File: rtl/serv_mem_arbiter.sv
// serv_mem_arbiter: shares one Wishbone-classic memory port between SERV ibus and dbus
module serv_mem_arbiter #(
    parameter string PRIO      = "DBUS",
    parameter int    TIMEOUT_W = 8,
    parameter bit    WITH_TO   = 1'b1
) (
    input logic               i_clk,
    input logic               i_rst,
    serv_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IBUS, DBUS, DONE} state_t;
    localparam bit RR = (PRIO == "RR");
    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, irdt_q, irdt_d, drdt_q, drdt_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d, cyc_q, cyc_d, iack_q, iack_d, dack_q, dack_d, err_q, err_d;
    logic        pick_d, is_d, gnt_cyc, to_hit;
    // last_q = 1 when dbus held the most recent grant; only consulted on a tie in RR mode
    assign pick_d  = bus.i_dbus_cyc & (~bus.i_ibus_cyc | ~RR | ~last_q);
    assign is_d    = state_q == DBUS;
    assign gnt_cyc = is_d ? bus.i_dbus_cyc : bus.i_ibus_cyc;
    generate
        if (WITH_TO) begin : g_wd
            logic [TIMEOUT_W-1:0] cnt_q;
            always_ff @(posedge i_clk or posedge i_rst)
                if (i_rst) cnt_q <= '0;
                else cnt_q <= (state_q == IDLE) ? '0 : cnt_q + 1'b1;
            // cycle 2**W-1 of an unacked transfer is the terminal one
            assign to_hit = cnt_q == {{(TIMEOUT_W-1){1'b1}}, 1'b0};
        end else begin : g_no_wd
            assign to_hit = 1'b0;
        end
    endgenerate
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        irdt_d  = irdt_q;
        drdt_d  = drdt_q;
        iack_d  = 1'b0;
        dack_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.i_ibus_cyc | bus.i_dbus_cyc) begin
                state_d = pick_d ? DBUS : IBUS;
                last_d  = pick_d;
                adr_d   = pick_d ? bus.i_dbus_adr : bus.i_ibus_adr;
                dat_d   = pick_d ? bus.i_dbus_dat : dat_q;
                sel_d   = pick_d ? bus.i_dbus_sel : 4'hF;
                we_d    = pick_d & bus.i_dbus_we;
                cyc_d   = 1'b1;
            end
            IBUS, DBUS: if (!gnt_cyc) begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end else if (bus.i_mem_ack | to_hit) begin
                state_d = DONE;
                cyc_d   = 1'b0;
                err_d   = ~bus.i_mem_ack;
                iack_d  = ~is_d;
                dack_d  = is_d;
                irdt_d  = is_d ? irdt_q : (bus.i_mem_ack ? bus.i_mem_rdt : 32'h0);
                drdt_d  = is_d ? (bus.i_mem_ack ? bus.i_mem_rdt : 32'h0) : drdt_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            irdt_q  <= '0;
            drdt_q  <= '0;
            iack_q  <= 1'b0;
            dack_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            irdt_q  <= irdt_d;
            drdt_q  <= drdt_d;
            iack_q  <= iack_d;
            dack_q  <= dack_d;
            err_q   <= err_d;
        end
    assign bus.o_mem_adr  = adr_q;
    assign bus.o_mem_dat  = dat_q;
    assign bus.o_mem_sel  = sel_q;
    assign bus.o_mem_we   = we_q;
    assign bus.o_mem_cyc  = cyc_q;
    assign bus.o_ibus_rdt = irdt_q;
    assign bus.o_ibus_ack = iack_q;
    assign bus.o_dbus_rdt = drdt_q;
    assign bus.o_dbus_ack = dack_q;
    assign bus.o_err      = err_q;
    assign bus.o_busy     = state_q != IDLE;
endmodule

// File: tb/tb_serv_mem_arbiter.sv
// tb_serv_mem_arbiter: scoreboard bench for the arbiter in fixed-priority and round-robin modes
module tb_serv_mem_arbiter;
    typedef struct packed {logic d; logic [31:0] rdt; logic err;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n;
    exp_t q0[$];
    exp_t e;
    serv_mem_arbiter_if b0();
    serv_mem_arbiter_if b1();
    serv_mem_arbiter #(.PRIO("DBUS"), .TIMEOUT_W(4), .WITH_TO(1'b1)) u_dut (.i_clk(clk), .i_rst(rst), .bus(b0));
    serv_mem_arbiter #(.PRIO("RR"),   .TIMEOUT_W(4), .WITH_TO(1'b1)) u_rr  (.i_clk(clk), .i_rst(rst), .bus(b1));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic d, input logic [31:0] rdt, input logic err);
        q0.push_back(exp_t'{d, rdt, err});
    endtask
    task automatic rr_tie(input logic exp_d);
        b1.i_ibus_cyc = 1'b1; b1.i_ibus_adr = 32'h10;
        b1.i_dbus_cyc = 1'b1; b1.i_dbus_adr = 32'h20;
        tick;
        chk("rr_adr", b1.o_mem_adr, exp_d ? 32'h20 : 32'h10);
        b1.i_mem_ack = 1'b1; b1.i_mem_rdt = 32'hABC;
        tick;
        chk("rr_dack", b1.o_dbus_ack, exp_d);
        chk("rr_iack", b1.o_ibus_ack, !exp_d);
        b1.i_ibus_cyc = 1'b0; b1.i_dbus_cyc = 1'b0; b1.i_mem_ack = 1'b0;
        tick;
        tick;
    endtask
    always @(negedge clk)
        if (!rst && (b0.o_ibus_ack || b0.o_dbus_ack)) begin
            if (q0.size() == 0) chk("sb_underflow", 32'(q0.size()), 32'd1);
            else begin
                e = q0.pop_front();
                chk("sb_bus", b0.o_dbus_ack, e.d);
                chk("sb_both", b0.o_ibus_ack & b0.o_dbus_ack, 1'b0);
                chk("sb_rdt", e.d ? b0.o_dbus_rdt : b0.o_ibus_rdt, e.rdt);
                chk("sb_err", b0.o_err, e.err);
            end
        end
    initial begin
        #200000;
        $display("FAIL time_limit: got timeout expected finish");
        $fatal(1, "time limit");
    end
    initial begin
        b0.i_ibus_adr = '0; b0.i_ibus_cyc = 0; b0.i_dbus_adr = '0; b0.i_dbus_dat = '0;
        b0.i_dbus_sel = '0; b0.i_dbus_we = 0; b0.i_dbus_cyc = 0; b0.i_mem_rdt = '0; b0.i_mem_ack = 0;
        b1.i_ibus_adr = '0; b1.i_ibus_cyc = 0; b1.i_dbus_adr = '0; b1.i_dbus_dat = '0;
        b1.i_dbus_sel = '0; b1.i_dbus_we = 0; b1.i_dbus_cyc = 0; b1.i_mem_rdt = '0; b1.i_mem_ack = 0;
        tick;
        tick;
        chk("rst_memcyc", b0.o_mem_cyc, 1'b0);
        chk("rst_busy", b0.o_busy, 1'b0);
        chk("rst_acks", {b0.o_ibus_ack, b0.o_dbus_ack, b0.o_err}, 3'b000);
        chk("rst_adr", b0.o_mem_adr, 32'h0);
        chk("rst_sel", b0.o_mem_sel, 4'h0);
        rst = 1'b0;
        tick;
        // single ibus fetch acked on the first memory cycle
        b0.i_ibus_cyc = 1'b1; b0.i_ibus_adr = 32'h100;
        tick;
        chk("i_memcyc", b0.o_mem_cyc, 1'b1);
        chk("i_adr", b0.o_mem_adr, 32'h100);
        chk("i_sel", b0.o_mem_sel, 4'hF);
        chk("i_we", b0.o_mem_we, 1'b0);
        chk("i_busy", b0.o_busy, 1'b1);
        b0.i_mem_ack = 1'b1; b0.i_mem_rdt = 32'h13; push(1'b0, 32'h13, 1'b0);
        tick;
        chk("i_ack", b0.o_ibus_ack, 1'b1);
        chk("i_memcyc_off", b0.o_mem_cyc, 1'b0);
        b0.i_ibus_cyc = 1'b0; b0.i_mem_rdt = 32'h99;
        tick;
        chk("done_stray_ack", b0.o_ibus_ack, 1'b0);
        chk("done_busy", b0.o_busy, 1'b0);
        chk("i_rdt_hold", b0.o_ibus_rdt, 32'h13);
        b0.i_mem_ack = 1'b0;
        tick;
        // simultaneous requests: dbus wins, ibus follows after DONE+IDLE
        b0.i_ibus_cyc = 1'b1; b0.i_ibus_adr = 32'h200;
        b0.i_dbus_cyc = 1'b1; b0.i_dbus_adr = 32'h300; b0.i_dbus_dat = 32'hDEADBEEF;
        b0.i_dbus_sel = 4'b0011; b0.i_dbus_we = 1'b1;
        tick;
        chk("t_adr", b0.o_mem_adr, 32'h300);
        chk("t_dat", b0.o_mem_dat, 32'hDEADBEEF);
        chk("t_sel", b0.o_mem_sel, 4'b0011);
        chk("t_we", b0.o_mem_we, 1'b1);
        b0.i_mem_ack = 1'b1; b0.i_mem_rdt = 32'h11112222; push(1'b1, 32'h11112222, 1'b0);
        tick;
        chk("t_iack_wait", b0.o_ibus_ack, 1'b0);
        b0.i_dbus_cyc = 1'b0; b0.i_dbus_we = 1'b0; b0.i_mem_ack = 1'b0;
        tick;
        chk("t_gap", b0.o_mem_cyc, 1'b0);
        tick;
        chk("t2_adr", b0.o_mem_adr, 32'h200);
        chk("t2_sel", b0.o_mem_sel, 4'hF);
        chk("t2_we", b0.o_mem_we, 1'b0);
        b0.i_mem_ack = 1'b1; b0.i_mem_rdt = 32'hCAFE0001; push(1'b0, 32'hCAFE0001, 1'b0);
        tick;
        chk("t2_drdt_kept", b0.o_dbus_rdt, 32'h11112222);
        b0.i_ibus_cyc = 1'b0; b0.i_mem_ack = 1'b0;
        tick;
        // watchdog termination with no ack at all
        b0.i_dbus_cyc = 1'b1; b0.i_dbus_adr = 32'h400; b0.i_dbus_sel = 4'hF; b0.i_mem_rdt = 32'hFFFFFFFF;
        push(1'b1, 32'h0, 1'b1);
        tick;
        n = 0;
        while (b0.o_mem_cyc && n < 40) begin
            n++;
            tick;
        end
        chk("to_cycles", n, 15);
        chk("to_err", b0.o_err, 1'b1);
        chk("to_dack", b0.o_dbus_ack, 1'b1);
        chk("to_rdt", b0.o_dbus_rdt, 32'h0);
        b0.i_dbus_cyc = 1'b0;
        tick;
        chk("to_err_off", b0.o_err, 1'b0);
        chk("to_idle", b0.o_busy, 1'b0);
        // ack on the terminal watchdog cycle is a normal completion
        b0.i_dbus_cyc = 1'b1; b0.i_dbus_adr = 32'h404;
        tick;
        repeat (14) tick;
        chk("term_memcyc", b0.o_mem_cyc, 1'b1);
        b0.i_mem_ack = 1'b1; b0.i_mem_rdt = 32'h5A5A; push(1'b1, 32'h5A5A, 1'b0);
        tick;
        chk("term_err", b0.o_err, 1'b0);
        chk("term_dack", b0.o_dbus_ack, 1'b1);
        b0.i_dbus_cyc = 1'b0; b0.i_mem_ack = 1'b0;
        tick;
        // abort beats a simultaneous ack
        b0.i_dbus_cyc = 1'b1; b0.i_dbus_adr = 32'h500;
        tick;
        tick;
        b0.i_dbus_cyc = 1'b0; b0.i_mem_ack = 1'b1;
        tick;
        chk("ab_memcyc", b0.o_mem_cyc, 1'b0);
        chk("ab_dack", b0.o_dbus_ack, 1'b0);
        chk("ab_err", b0.o_err, 1'b0);
        chk("ab_busy", b0.o_busy, 1'b0);
        // stray ack while idle
        tick;
        tick;
        chk("st_busy", b0.o_busy, 1'b0);
        chk("st_acks", {b0.o_ibus_ack, b0.o_dbus_ack, b0.o_err}, 3'b000);
        chk("st_memcyc", b0.o_mem_cyc, 1'b0);
        b0.i_mem_ack = 1'b0;
        tick;
        // asynchronous reset in the middle of a dbus grant
        b0.i_dbus_cyc = 1'b1; b0.i_dbus_adr = 32'h600;
        tick;
        chk("rs_memcyc_pre", b0.o_mem_cyc, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rs_memcyc", b0.o_mem_cyc, 1'b0);
        chk("rs_busy", b0.o_busy, 1'b0);
        b0.i_dbus_cyc = 1'b0;
        tick;
        rst = 1'b0;
        b0.i_ibus_cyc = 1'b1; b0.i_ibus_adr = 32'h700;
        tick;
        chk("rs_i_memcyc", b0.o_mem_cyc, 1'b1);
        chk("rs_i_adr", b0.o_mem_adr, 32'h700);
        b0.i_mem_ack = 1'b1; b0.i_mem_rdt = 32'h700A; push(1'b0, 32'h700A, 1'b0);
        tick;
        chk("rs_i_ack", b0.o_ibus_ack, 1'b1);
        b0.i_ibus_cyc = 1'b0; b0.i_mem_ack = 1'b0;
        tick;
        // round-robin ties alternate, starting with dbus since ibus is last-grant after reset
        rr_tie(1'b1);
        rr_tie(1'b0);
        rr_tie(1'b1);
        chk("sb_empty", 32'(q0.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
